// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the SIPO word assembler.
// Optional feature macro: SIPO_PARITY_EN (adds an odd-parity bit per frame).
package sipo_pkg;

`ifdef SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-FRAME bit counter with clear and a wrap strobe.
// The wrap strobe marks the edge that shifts the last bit of a frame.
module sipo_bit_counter #(
  parameter int FRAME = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  logic last;

  assign last = (cnt == CW'(FRAME - 1));
  assign wrap = en & ~clr & last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_word_assembler.sv
// Serial-in/parallel-out word assembler with valid/ready holding register.
// Optional feature macro: SIPO_PARITY_EN (odd parity bit, parity_err port).
module sipo_word_assembler
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             shift_en,
  input  logic             flush,
  output logic [WIDTH-1:0] word_q,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic [CW-1:0]    bit_cnt
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int FRAME = WIDTH + PAR_BITS;

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nx;
  logic [WIDTH-1:0] word_nx;
  logic             wrap;
  logic             xfer;
  logic             load;
  logic             drop;

  sipo_bit_counter #(
    .FRAME (FRAME),
    .CW    (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .clr  (flush),
    .cnt  (bit_cnt),
    .wrap (wrap)
  );

  always_comb begin
    sr_nx = MSB_FIRST ? {sr[WIDTH-2:0], d}
                      : {d, sr[WIDTH-1:1]};
  end

`ifdef SIPO_PARITY_EN
  // Last frame bit is parity: data is already complete in sr
  logic perr_nx;
  assign word_nx = sr;
  assign perr_nx = ~(^sr ^ d);
`else
  assign word_nx = sr_nx;
`endif

  assign xfer = word_valid & word_ready;
  assign load = wrap & (~word_valid | xfer);
  assign drop = wrap & word_valid & ~xfer;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= sr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q     <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= drop;
      if (load) begin
        word_q     <= word_nx;
        word_valid <= 1'b1;
      end else if (xfer) begin
        word_valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= perr_nx;
    end
  end
`endif

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Directed bench for sipo_word_assembler (WIDTH=8, both bit orders).
// Optional feature macro: SIPO_PARITY_EN.
module tb_sipo_word_assembler;

  logic       clk = 1'b0;
  logic       rst, d, shift_en, flush, word_ready;
  logic [7:0] word_q, word_q_l;
  logic       word_valid, word_valid_l;
  logic       overrun, overrun_l;
  logic [3:0] bit_cnt, bit_cnt_l;
`ifdef SIPO_PARITY_EN
  logic       parity_err, parity_err_l;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sipo_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .d(d), .shift_en(shift_en), .flush(flush),
    .word_q(word_q), .word_valid(word_valid), .word_ready(word_ready),
    .overrun(overrun), .bit_cnt(bit_cnt)
`ifdef SIPO_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  sipo_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .d(d), .shift_en(shift_en), .flush(flush),
    .word_q(word_q_l), .word_valid(word_valid_l), .word_ready(word_ready),
    .overrun(overrun_l), .bit_cnt(bit_cnt_l)
`ifdef SIPO_PARITY_EN
    , .parity_err(parity_err_l)
`endif
  );

  typedef struct {
    logic       rst, d, se, fl, rdy;
    logic       ev;
    logic [7:0] ew, ewl;
    logic       eo;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic dd, input logic se,
                      input logic fl, input logic rdy);
    rst = r; d = dd; shift_en = se; flush = fl; word_ready = rdy;
    @(posedge clk);
    #1;
    rst = 1'b0; shift_en = 1'b0; flush = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic p,
                            input logic rb, input logic rl);
    for (int i = 7; i >= 0; i--) begin
`ifdef SIPO_PARITY_EN
      step(1'b0, data[i], 1'b1, 1'b0, rb);
`else
      step(1'b0, data[i], 1'b1, 1'b0, (i == 0) ? rl : rb);
`endif
    end
`ifdef SIPO_PARITY_EN
    step(1'b0, p, 1'b1, 1'b0, rl);
`else
    if (p) begin end
`endif
  endtask

  task automatic send_word(input logic [7:0] data, input logic rb,
                           input logic rl);
    send_frame(data, ~^data, rb, rl);
  endtask

  function automatic vec_t mk(input logic r, dd, se, fl, rdy, ev,
                              input logic [7:0] ew, ewl,
                              input logic eo, input logic [3:0] ec);
    vec_t v;
    v.rst = r; v.d = dd; v.se = se; v.fl = fl; v.rdy = rdy;
    v.ev = ev; v.ew = ew; v.ewl = ewl; v.eo = eo; v.ec = ec;
    return v;
  endfunction

  initial begin
    rst = 1'b1; d = 1'b0; shift_en = 1'b0; flush = 1'b0;
    word_ready = 1'b0;
    @(posedge clk);
    #1;

`ifndef SIPO_PARITY_EN
    // T1/T2: stream 1,0,1,1,0,0,1,0 with ready=1
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 2));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 3));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 4));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 5));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 0, 6));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 7));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 8'hB2, 8'h4D, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'hB2, 8'h4D, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 8'hB2, 8'h4D, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 8'hB2, 8'h4D, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 8'hB2, 8'h4D, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'hB2, 8'h4D, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].d, tbl[i].se, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("v%0d valid", i), {31'd0, word_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("v%0d word", i), {24'd0, word_q}, {24'd0, tbl[i].ew});
      chk($sformatf("v%0d word_lsb", i), {24'd0, word_q_l}, {24'd0, tbl[i].ewl});
      chk($sformatf("v%0d overrun", i), {31'd0, overrun}, {31'd0, tbl[i].eo});
      chk($sformatf("v%0d bit_cnt", i), {28'd0, bit_cnt}, {28'd0, tbl[i].ec});
    end
`else
    chk("reset valid", {31'd0, word_valid}, 32'd0);
    chk("reset bit_cnt", {28'd0, bit_cnt}, 32'd0);
`endif

    // T3: holding register full, second word dropped
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hB2, 1'b0, 1'b0);
    chk("t3 valid1", {31'd0, word_valid}, 32'd1);
    chk("t3 word1", {24'd0, word_q}, 32'hB2);
    chk("t3 no_ovr", {31'd0, overrun}, 32'd0);
    send_word(8'hFF, 1'b0, 1'b0);
    chk("t3 ovr", {31'd0, overrun}, 32'd1);
    chk("t3 word_kept", {24'd0, word_q}, 32'hB2);
    chk("t3 valid_kept", {31'd0, word_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3 ovr_pulse", {31'd0, overrun}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3 drained", {31'd0, word_valid}, 32'd0);

    // T4: transfer and completion on the same edge
    send_word(8'h11, 1'b0, 1'b0);
    chk("t4 word1", {24'd0, word_q}, 32'h11);
    send_word(8'h22, 1'b0, 1'b1);
    chk("t4 valid_stays", {31'd0, word_valid}, 32'd1);
    chk("t4 word2", {24'd0, word_q}, 32'h22);
    chk("t4 no_ovr", {31'd0, overrun}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4 drained", {31'd0, word_valid}, 32'd0);

    // T5a: flush discards partial word
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5 cnt3", {28'd0, bit_cnt}, 32'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5 flush_cnt", {28'd0, bit_cnt}, 32'd0);
    send_word(8'hA5, 1'b0, 1'b0);
    chk("t5 wordA5", {24'd0, word_q}, 32'hA5);
    chk("t5 validA5", {31'd0, word_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5 flush_keeps_valid", {31'd0, word_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // T5b: reset mid-word
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5 rst_cnt", {28'd0, bit_cnt}, 32'd0);
    chk("t5 rst_word", {24'd0, word_q}, 32'd0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("t5 word3C", {24'd0, word_q}, 32'h3C);
    chk("t5 cnt_wrap", {28'd0, bit_cnt}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    // T6: odd parity
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    chk("t6 word", {24'd0, word_q}, 32'h07);
    chk("t6 perr0", {31'd0, parity_err}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    chk("t6 perr1", {31'd0, parity_err}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
